// File: rtl/reg_file_sb_if.sv
// Register-file access bus: two read ports, one write port, accumulator view
// and the load-pending scoreboard.
interface reg_file_sb_if #(
    parameter int DW  = 8,
    parameter int RAW = 4
);
    logic [RAW-1:0]      rs_addr_i;
    logic [RAW-1:0]      rt_addr_i;
    logic                wen_i;
    logic                acc_mode_i;
    logic [RAW-1:0]      wr_addr_i;
    logic [DW-1:0]       write_data_i;
    logic                pend_set_i;
    logic [RAW-1:0]      pend_addr_i;
    logic [DW-1:0]       rs_val_o;
    logic [DW-1:0]       rt_val_o;
    logic [DW-1:0]       acc_val_o;
    logic                stall_o;
    logic [2**RAW-1:0]   pend_o;

    modport master (
        output rs_addr_i, rt_addr_i, wen_i, acc_mode_i, wr_addr_i,
               write_data_i, pend_set_i, pend_addr_i,
        input  rs_val_o, rt_val_o, acc_val_o, stall_o, pend_o
    );

    modport slave (
        input  rs_addr_i, rt_addr_i, wen_i, acc_mode_i, wr_addr_i,
               write_data_i, pend_set_i, pend_addr_i,
        output rs_val_o, rt_val_o, acc_val_o, stall_o, pend_o
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with write-to-read forwarding, an accumulator write mode and a
// per-register pending scoreboard that raises stall for in-flight loads.
module reg_file_sb #(
    parameter int DW      = 8,
    parameter int RAW     = 4,
    parameter int ACC_IDX = 1,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int             NREG  = 2**RAW;
    localparam logic [RAW-1:0] ACC_A = RAW'(ACC_IDX);

    logic [DW-1:0]   rf_q [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [RAW-1:0]  wa;
    logic            wr_ok;
    logic            ps_ok;

    function automatic logic [DW-1:0] fwd_val(
        input logic [RAW-1:0] a,
        input logic [DW-1:0]  stored,
        input logic [RAW-1:0] w_addr,
        input logic           w_ok,
        input logic [DW-1:0]  w_data
    );
        if (ZERO_R0 != 0 && a == '0)
            return '0;
        if (BYPASS != 0 && w_ok && a == w_addr)
            return w_data;
        return stored;
    endfunction

    // A pending register being written this cycle is satisfied only when the
    // write data is forwarded to the reader.
    function automatic logic pend_hit(
        input logic [RAW-1:0] a,
        input logic           p,
        input logic [RAW-1:0] w_addr,
        input logic           w_ok
    );
        return p && !(BYPASS != 0 && w_ok && a == w_addr);
    endfunction

    always_comb begin
        wa     = bus.acc_mode_i ? ACC_A : bus.wr_addr_i;
        wr_ok  = bus.wen_i && !(ZERO_R0 != 0 && wa == '0);
        ps_ok  = bus.pend_set_i && !(ZERO_R0 != 0 && bus.pend_addr_i == '0);
        pend_d = pend_q;
        if (wr_ok)
            pend_d[wa] = 1'b0;
        if (ps_ok)
            pend_d[bus.pend_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
            pend_q <= '0;
        end else begin
            if (wr_ok)
                rf_q[wa] <= bus.write_data_i;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        bus.rs_val_o  = fwd_val(bus.rs_addr_i, rf_q[bus.rs_addr_i], wa, wr_ok, bus.write_data_i);
        bus.rt_val_o  = fwd_val(bus.rt_addr_i, rf_q[bus.rt_addr_i], wa, wr_ok, bus.write_data_i);
        bus.acc_val_o = fwd_val(ACC_A, rf_q[ACC_A], wa, wr_ok, bus.write_data_i);
        bus.stall_o   = pend_hit(bus.rs_addr_i, pend_q[bus.rs_addr_i], wa, wr_ok)
                      | pend_hit(bus.rt_addr_i, pend_q[bus.rt_addr_i], wa, wr_ok);
        bus.pend_o    = pend_q;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default, no-bypass and zero-r0 builds driven in
// lockstep and compared against an array-based model of the register file.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DW(8), .RAW(4)) ifd ();
    reg_file_sb_if #(.DW(8), .RAW(4)) ifn ();
    reg_file_sb_if #(.DW(8), .RAW(4)) ifz ();

    reg_file_sb #(.DW(8), .RAW(4)) dut_d (.clk(clk), .rst(rst), .bus(ifd));
    reg_file_sb #(.DW(8), .RAW(4), .BYPASS(0)) dut_n (.clk(clk), .rst(rst), .bus(ifn));
    reg_file_sb #(.DW(8), .RAW(4), .ZERO_R0(1)) dut_z (.clk(clk), .rst(rst), .bus(ifz));

    int checks   = 0;
    int failures = 0;

    // current stimulus, shared by all three builds
    int       t_rs, t_rt, t_wa, t_pa;
    logic     t_wen, t_acc, t_ps;
    logic [7:0] t_wd;

    // model: config 0 = default, 1 = no bypass, 2 = zero r0
    logic [7:0] m_rf   [3][16];
    logic       m_pend [3][16];

    typedef struct {
        int rs; int rt; logic wen; logic acc; int wa; logic [7:0] wd; logic ps; int pa;
        logic [7:0] e_rs; logic [7:0] e_rt; logic [7:0] e_acc; logic e_stall; logic [15:0] e_pend;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int eff_wa();
        return t_acc ? 1 : t_wa;
    endfunction

    function automatic logic wr_takes(int c);
        return t_wen && !(c == 2 && eff_wa() == 0);
    endfunction

    function automatic logic [7:0] exp_rd(int c, int a);
        if (c == 2 && a == 0) return 8'h00;
        if (c != 1 && wr_takes(c) && a == eff_wa()) return t_wd;
        return m_rf[c][a];
    endfunction

    function automatic logic exp_stall(int c);
        logic s = 1'b0;
        int   addrs [2];
        addrs[0] = t_rs;
        addrs[1] = t_rt;
        foreach (addrs[k])
            if (m_pend[c][addrs[k]] && !(c != 1 && wr_takes(c) && addrs[k] == eff_wa()))
                s = 1'b1;
        return s;
    endfunction

    function automatic logic [15:0] exp_pend(int c);
        logic [15:0] p = '0;
        for (int i = 0; i < 16; i++) p[i] = m_pend[c][i];
        return p;
    endfunction

    task automatic check_cfg(input int c, input string tag, input logic [7:0] rs, input logic [7:0] rt,
                             input logic [7:0] acc, input logic st, input logic [15:0] pd);
        chk({tag, "_rs"}, rs, exp_rd(c, t_rs));
        chk({tag, "_rt"}, rt, exp_rd(c, t_rt));
        chk({tag, "_acc"}, acc, exp_rd(c, 1));
        chk({tag, "_stall"}, st, exp_stall(c));
        chk({tag, "_pend"}, pd, exp_pend(c));
    endtask

    task automatic check_all();
        check_cfg(0, "def", ifd.rs_val_o, ifd.rt_val_o, ifd.acc_val_o, ifd.stall_o, ifd.pend_o);
        check_cfg(1, "nob", ifn.rs_val_o, ifn.rt_val_o, ifn.acc_val_o, ifn.stall_o, ifn.pend_o);
        check_cfg(2, "zr0", ifz.rs_val_o, ifz.rt_val_o, ifz.acc_val_o, ifz.stall_o, ifz.pend_o);
    endtask

    task automatic drive(input int rs, input int rt, input logic wen, input logic acc, input int wa,
                         input logic [7:0] wd, input logic ps, input int pa);
        t_rs = rs; t_rt = rt; t_wen = wen; t_acc = acc; t_wa = wa; t_wd = wd; t_ps = ps; t_pa = pa;
        ifd.rs_addr_i = 4'(rs); ifn.rs_addr_i = 4'(rs); ifz.rs_addr_i = 4'(rs);
        ifd.rt_addr_i = 4'(rt); ifn.rt_addr_i = 4'(rt); ifz.rt_addr_i = 4'(rt);
        ifd.wen_i = wen; ifn.wen_i = wen; ifz.wen_i = wen;
        ifd.acc_mode_i = acc; ifn.acc_mode_i = acc; ifz.acc_mode_i = acc;
        ifd.wr_addr_i = 4'(wa); ifn.wr_addr_i = 4'(wa); ifz.wr_addr_i = 4'(wa);
        ifd.write_data_i = wd; ifn.write_data_i = wd; ifz.write_data_i = wd;
        ifd.pend_set_i = ps; ifn.pend_set_i = ps; ifz.pend_set_i = ps;
        ifd.pend_addr_i = 4'(pa); ifn.pend_addr_i = 4'(pa); ifz.pend_addr_i = 4'(pa);
    endtask

    // Clock edge, then apply the architectural update to the model.
    task automatic advance();
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    m_rf[c][i]   = 8'h00;
                    m_pend[c][i] = 1'b0;
                end
            end else begin
                if (wr_takes(c)) begin
                    m_rf[c][eff_wa()]   = t_wd;
                    m_pend[c][eff_wa()] = 1'b0;
                end
                if (t_ps && !(c == 2 && t_pa == 0))
                    m_pend[c][t_pa] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step(input int rs, input int rt, input logic wen, input logic acc, input int wa,
                        input logic [7:0] wd, input logic ps, input int pa);
        drive(rs, rt, wen, acc, wa, wd, ps, pa);
        @(negedge clk);
        check_all();
        advance();
    endtask

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0,  8'h00, 8'h00, 8'h00, 0, 16'h0000};
        vecs[1]  = '{1, 7, 1, 1, 7, 8'h5A, 0, 0,  8'h5A, 8'h00, 8'h5A, 0, 16'h0000};
        vecs[2]  = '{1, 7, 0, 0, 0, 8'h00, 0, 0,  8'h5A, 8'h00, 8'h5A, 0, 16'h0000};
        vecs[3]  = '{3, 0, 0, 0, 0, 8'h00, 1, 3,  8'h00, 8'h00, 8'h5A, 0, 16'h0000};
        vecs[4]  = '{3, 0, 0, 0, 0, 8'h00, 0, 0,  8'h00, 8'h00, 8'h5A, 1, 16'h0008};
        vecs[5]  = '{3, 0, 1, 0, 3, 8'h77, 0, 0,  8'h77, 8'h00, 8'h5A, 0, 16'h0008};
        vecs[6]  = '{3, 0, 0, 0, 0, 8'h00, 0, 0,  8'h77, 8'h00, 8'h5A, 0, 16'h0000};
        vecs[7]  = '{5, 3, 1, 0, 5, 8'h11, 1, 5,  8'h11, 8'h77, 8'h5A, 0, 16'h0000};
        vecs[8]  = '{5, 0, 0, 0, 0, 8'h00, 0, 0,  8'h11, 8'h00, 8'h5A, 1, 16'h0020};
        vecs[9]  = '{0, 5, 0, 0, 0, 8'h00, 1, 5,  8'h00, 8'h11, 8'h5A, 1, 16'h0020};
        vecs[10] = '{5, 2, 1, 0, 5, 8'h22, 1, 2,  8'h22, 8'h00, 8'h5A, 0, 16'h0020};
        vecs[11] = '{5, 2, 0, 0, 0, 8'h00, 0, 0,  8'h22, 8'h00, 8'h5A, 1, 16'h0004};

        drive(0, 0, 0, 0, 0, 8'h00, 0, 0);
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;

        // every address reads zero after reset
        for (int i = 0; i < 16; i++)
            step(i, 15 - i, 0, 0, 0, 8'h00, 0, 0);

        // directed table on the default build
        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].rs, vecs[v].rt, vecs[v].wen, vecs[v].acc, vecs[v].wa,
                  vecs[v].wd, vecs[v].ps, vecs[v].pa);
            @(negedge clk);
            chk($sformatf("vec%0d_rs", v), ifd.rs_val_o, vecs[v].e_rs);
            chk($sformatf("vec%0d_rt", v), ifd.rt_val_o, vecs[v].e_rt);
            chk($sformatf("vec%0d_acc", v), ifd.acc_val_o, vecs[v].e_acc);
            chk($sformatf("vec%0d_stall", v), ifd.stall_o, vecs[v].e_stall);
            chk($sformatf("vec%0d_pend", v), ifd.pend_o, vecs[v].e_pend);
            check_all();
            advance();
        end

        // no-bypass build: same-cycle write invisible, next cycle visible
        step(0, 0, 1, 0, 2, 8'h10, 0, 0);
        drive(0, 2, 1, 0, 2, 8'h33, 0, 0);
        @(negedge clk);
        chk("nob_old_rt", ifn.rt_val_o, 8'h10);
        chk("def_fwd_rt", ifd.rt_val_o, 8'h33);
        check_all();
        advance();
        drive(0, 2, 0, 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        chk("nob_new_rt", ifn.rt_val_o, 8'h33);
        check_all();
        advance();

        // no-bypass build stalls on a pending register even while it is written
        step(0, 0, 0, 0, 0, 8'h00, 1, 9);
        drive(9, 0, 1, 0, 9, 8'h44, 0, 0);
        @(negedge clk);
        chk("nob_stall_wr", ifn.stall_o, 1'b1);
        chk("def_nostall_wr", ifd.stall_o, 1'b0);
        check_all();
        advance();

        // reset overrides a same-cycle write and pend-set, clearing old marks
        step(0, 0, 0, 0, 0, 8'h00, 1, 12);
        rst = 1'b1;
        drive(0, 0, 1, 0, 4, 8'hFF, 1, 6);
        advance();
        rst = 1'b0;
        drive(4, 6, 0, 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        chk("rst_rf4", ifd.rs_val_o, 8'h00);
        chk("rst_pend", ifd.pend_o, 16'h0000);
        chk("rst_stall", ifd.stall_o, 1'b0);
        check_all();
        advance();

        // zero-r0 build: register 0 ignores writes and pend-sets
        drive(0, 0, 1, 0, 0, 8'hAB, 1, 0);
        @(negedge clk);
        chk("zr0_same", ifz.rs_val_o, 8'h00);
        chk("def_r0_fwd", ifd.rs_val_o, 8'hAB);
        check_all();
        advance();
        drive(0, 0, 0, 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        chk("zr0_next", ifz.rs_val_o, 8'h00);
        chk("zr0_pend0", ifz.pend_o[0], 1'b0);
        chk("def_r0_kept", ifd.rs_val_o, 8'hAB);
        chk("def_pend0", ifd.pend_o[0], 1'b1);
        check_all();
        advance();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 15), 8'($urandom),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 15));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DW, default 8: data width of every register and data port.
REQ-002 Parameter RAW, default 4: address width; the file holds 2**RAW registers.
REQ-003 Parameter ACC_IDX, default 1: index of the accumulator register targeted by accumulator-mode writes.
REQ-004 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-005 Parameter ZERO_R0, default 0: 1 makes register 0 read as zero and ignore all writes and pending-sets.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 rs_addr_i  input  RAW  read pointer for port RS.
REQ-009 rt_addr_i  input  RAW  read pointer for port RT.
REQ-010 wen_i  input  1  write enable.
REQ-011 acc_mode_i  input  1  1 = write targets ACC_IDX; 0 = write targets wr_addr_i.
REQ-012 wr_addr_i  input  RAW  write pointer used when acc_mode_i = 0.
REQ-013 write_data_i  input  DW  write data.
REQ-014 pend_set_i  input  1  marks register pend_addr_i as pending (load in flight).
REQ-015 pend_addr_i  input  RAW  register to mark pending.
REQ-016 rs_val_o  output  DW  RS read data.
REQ-017 rt_val_o  output  DW  RT read data.
REQ-018 acc_val_o  output  DW  current content of register ACC_IDX, same forwarding rules as read ports.
REQ-019 stall_o  output  1  1 when a read port addresses a pending register whose value is not yet available.
REQ-020 pend_o  output  2**RAW  pending bit per register, bit i = register i.

Function
REQ-021 Effective write address WA = ACC_IDX when acc_mode_i = 1, else wr_addr_i.
REQ-022 On a rising edge with wen_i = 1 and rst = 0, RF[WA] <= write_data_i; one write per cycle, no other register changes.
REQ-023 Reads are combinational: rs_val_o = RF[rs_addr_i], rt_val_o = RF[rt_addr_i], zero latency.
REQ-024 BYPASS = 1: if wen_i = 1 and a read address equals WA, that port outputs write_data_i in the same cycle; applies to RS, RT and acc_val_o independently.
REQ-025 BYPASS = 0: reads always return stored content; a same-cycle write becomes visible the next cycle.
REQ-026 Scoreboard: pend_set_i = 1 sets pend[pend_addr_i] at the edge; wen_i = 1 clears pend[WA] at the edge.
REQ-027 Simultaneous pend_set_i and wen_i on the same address: set wins (pending stays 1, data still written).
REQ-028 Simultaneous pend_set_i and wen_i on different addresses: both take effect.
REQ-029 pend_set_i on an already-pending register keeps it pending; no counting of outstanding loads.
REQ-030 stall_o = (pend[rs_addr_i] or pend[rt_addr_i]) after forwarding: with BYPASS = 1 a pending register being written this cycle (wen_i = 1, WA match) does not cause stall; with BYPASS = 0 it does.
REQ-031 stall_o is purely combinational from current pend state and inputs; the block never blocks writes itself.
REQ-032 ZERO_R0 = 1: address 0 reads 0 on all ports (forwarding suppressed), writes and pend_set_i to 0 ignored, pend_o[0] constant 0.
REQ-033 All address wrap is natural to RAW bits; no out-of-range addresses exist.

Reset
REQ-034 rst = 1 at a rising edge clears all registers to 0 and all pend bits to 0.
REQ-035 rst overrides wen_i and pend_set_i in the same cycle; neither takes effect.
REQ-036 After reset: rs_val_o = rt_val_o = acc_val_o = 0, pend_o = 0, stall_o = 0 (absent same-cycle forwarding).
REQ-037 Reset mid-operation discards all pending marks; no stale pending bit survives.

Verification
REQ-038 Reset, then read all 16 addresses (defaults) -> every read 0, pend_o = 0x0000, stall_o = 0.
REQ-039 wen_i=1, acc_mode_i=1, write_data_i=0x5A -> same cycle acc_val_o = 0x5A (bypass); next cycle RF[1] = 0x5A, wr_addr_i ignored.
REQ-040 pend_set_i=1, pend_addr_i=3; next cycle rs_addr_i=3 -> stall_o = 1, pend_o = 0x0008; then wen_i=1, wr_addr_i=3, data 0x77 -> same cycle stall_o = 0, rs_val_o = 0x77; next cycle pend_o = 0.
REQ-041 Same edge pend_set_i to 5 and wen_i to 5 with 0x11 -> RF[5] = 0x11, pend_o[5] = 1.
REQ-042 BYPASS=0 build: write 0x33 to 2 while rt_addr_i=2 -> rt_val_o shows old value that cycle, 0x33 next.
REQ-043 rst=1 with wen_i=1 (addr 4, 0xFF) and pend_set_i (addr 6) -> after edge RF[4] = 0, pend_o = 0; ZERO_R0=1 build: write 0xAB to 0 -> reads of 0 stay 0.
